// File: rtl/train_pkg.sv
// Shared defaults and replay FSM encoding for the training replay buffer.
package train_pkg;

    localparam int DATA_SIZE = 16;
    localparam int SIZE      = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2
    } replay_state_e;

endpackage

// File: rtl/train_replay_mem.sv
// Sample-pair storage: one write port, one registered read port.
// Only the read register is reset; the array itself is not.
module train_replay_mem #(
    parameter int width  = 96,
    parameter int depth  = 4,
    parameter int addr_w = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [addr_w-1:0] waddr_i,
    input  logic [width-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [addr_w-1:0] raddr_i,
    output logic [width-1:0]  rdata_o
);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds the last fetched pair until the next fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/train_replay_buffer.sv
// Circular replay buffer of {x, prediction} pairs with an IDLE/FETCH/PRESENT replay FSM.
// Define TRAIN_REPLAY_OVERWRITE_EN to let captures overwrite the oldest entry when full.
module train_replay_buffer
    import train_pkg::*;
#(
    parameter int data_size = DATA_SIZE,
    parameter int size      = SIZE,
    parameter int depth     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        capture_valid,
    output logic                        capture_ready,
    input  logic [data_size*size-1:0]   x_in,
    input  logic [data_size*size-1:0]   predict_in,
    input  logic                        replay_req,
    input  logic                        replay_ack,
    input  logic                        flush,
    output logic                        use_z,
    output logic [data_size*size-1:0]   z,
    output logic [data_size*size-1:0]   predict_value_old,
    output logic [$clog2(depth):0]      count,
    output logic                        empty,
    output logic                        full
);

    localparam int VW = data_size * size;
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);

    replay_state_e   state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop, overwrite;
    logic [2*VW-1:0] rdata;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

`ifdef TRAIN_REPLAY_OVERWRITE_EN
    assign capture_ready = 1'b1;
    // A pop in the same cycle already frees a slot, so no overwrite is needed then.
    assign overwrite     = push && full && !pop;
`else
    assign capture_ready = !full;
    assign overwrite     = 1'b0;
`endif

    assign push = capture_valid && capture_ready && !flush;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:    if (replay_req && !empty) state_d = FETCH;
            FETCH: begin
                pop     = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: if (replay_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            pop     = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop || overwrite) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop && !overwrite) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    train_replay_mem #(
        .width  (2 * VW),
        .depth  (depth),
        .addr_w (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({x_in, predict_in}),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign use_z             = (state_q == PRESENT);
    assign z                 = rdata[2*VW-1:VW];
    assign predict_value_old = rdata[VW-1:0];
    assign count             = count_q;

endmodule

// File: tb/tb_train_replay_buffer.sv
// Directed self-checking bench for train_replay_buffer (default parameters).
// Exercises reset, replay latency, concurrent push/pop, full policy, flush and wrap-around.
module tb_train_replay_buffer;

    localparam int VW = 48;

    logic          clk;
    logic          rst_n;
    logic          capture_valid;
    logic          capture_ready;
    logic [VW-1:0] x_in;
    logic [VW-1:0] predict_in;
    logic          replay_req;
    logic          replay_ack;
    logic          flush;
    logic          use_z;
    logic [VW-1:0] z;
    logic [VW-1:0] predict_value_old;
    logic [2:0]    count;
    logic          empty;
    logic          full;

    int compared   = 0;
    int mismatched = 0;

    train_replay_buffer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .capture_valid     (capture_valid),
        .capture_ready     (capture_ready),
        .x_in              (x_in),
        .predict_in        (predict_in),
        .replay_req        (replay_req),
        .replay_ack        (replay_ack),
        .flush             (flush),
        .use_z             (use_z),
        .z                 (z),
        .predict_value_old (predict_value_old),
        .count             (count),
        .empty             (empty),
        .full              (full)
    );

    always #5 clk = ~clk;

    // Three distinct 16-bit elements per vector so element ordering is also checked.
    function automatic logic [VW-1:0] mk(input int a);
        return {16'(a + 2), 16'(a + 1), 16'(a)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic cv, input logic [VW-1:0] x, input logic [VW-1:0] p,
                                 input logic rr, input logic ack, input logic fl);
        capture_valid = cv;
        x_in          = x;
        predict_in    = p;
        replay_req    = rr;
        replay_ack    = ack;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic capturePair(input int a, input int b);
        applyStimulus(1'b1, mk(a), mk(b), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReplay(input string tag, input int a, input int b, input int expCount);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput({tag, ".fetch_use_z"}, 64'(use_z), 64'd0);
        idleCycle();
        checkOutput({tag, ".use_z"}, 64'(use_z), 64'd1);
        checkOutput({tag, ".z"}, 64'(z), 64'(mk(a)));
        checkOutput({tag, ".pvo"}, 64'(predict_value_old), 64'(mk(b)));
        checkOutput({tag, ".count"}, 64'(count), 64'(expCount));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput({tag, ".ack_use_z"}, 64'(use_z), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        capture_valid = 1'b1;
        x_in          = mk(1);
        predict_in    = mk(11);
        replay_req    = 1'b0;
        replay_ack    = 1'b0;
        flush         = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.use_z", 64'(use_z), 64'd0);
        checkOutput("rst.z", 64'(z), 64'd0);
        checkOutput("rst.pvo", 64'(predict_value_old), 64'd0);
        checkOutput("rst.count", 64'(count), 64'd0);
        checkOutput("rst.empty", 64'(empty), 64'd1);
        checkOutput("rst.full", 64'(full), 64'd0);
        checkOutput("rst.ready", 64'(capture_ready), 64'd1);

        rst_n = 1'b1;
        capturePair(1, 11);
        checkOutput("post_rst.count", 64'(count), 64'd1);

        $display("[TB] basic capture and replay");
        capturePair(2, 12);
        capturePair(3, 13);
        checkOutput("cap3.count", 64'(count), 64'd3);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("lat.n1_use_z", 64'(use_z), 64'd0);
        idleCycle();
        checkOutput("lat.n2_use_z", 64'(use_z), 64'd1);
        checkOutput("lat.z", 64'(z), 64'(mk(1)));
        checkOutput("lat.pvo", 64'(predict_value_old), 64'(mk(11)));
        checkOutput("lat.count", 64'(count), 64'd2);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("hold.use_z", 64'(use_z), 64'd1);
        checkOutput("hold.z", 64'(z), 64'(mk(1)));
        checkOutput("hold.count", 64'(count), 64'd2);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("ack.use_z", 64'(use_z), 64'd0);
        checkOutput("ack.z_retained", 64'(z), 64'(mk(1)));

        $display("[TB] capture during fetch");
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, mk(4), mk(14), 1'b0, 1'b0, 1'b0);
        checkOutput("pushpop.count", 64'(count), 64'd2);
        checkOutput("pushpop.use_z", 64'(use_z), 64'd1);
        checkOutput("pushpop.z", 64'(z), 64'(mk(2)));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        doReplay("pp3", 3, 13, 1);
        doReplay("pp4", 4, 14, 0);
        checkOutput("pp.empty", 64'(empty), 64'd1);

        $display("[TB] full buffer policy");
        capturePair(21, 31);
        capturePair(22, 32);
        capturePair(23, 33);
        capturePair(24, 34);
        checkOutput("full.count", 64'(count), 64'd4);
        checkOutput("full.full", 64'(full), 64'd1);
`ifdef TRAIN_REPLAY_OVERWRITE_EN
        checkOutput("full.ready", 64'(capture_ready), 64'd1);
        capturePair(25, 35);
        checkOutput("ovw.count", 64'(count), 64'd4);
        doReplay("ovw22", 22, 32, 3);
        doReplay("ovw23", 23, 33, 2);
        doReplay("ovw24", 24, 34, 1);
        doReplay("ovw25", 25, 35, 0);
`else
        checkOutput("full.ready", 64'(capture_ready), 64'd0);
        capturePair(25, 35);
        checkOutput("refuse.count", 64'(count), 64'd4);
        doReplay("ref21", 21, 31, 3);
        doReplay("ref22", 22, 32, 2);
        doReplay("ref23", 23, 33, 1);
        doReplay("ref24", 24, 34, 0);
`endif

        $display("[TB] flush during present");
        capturePair(41, 51);
        capturePair(42, 52);
        capturePair(43, 53);
        capturePair(44, 54);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        idleCycle();
        checkOutput("fl.pre_use_z", 64'(use_z), 64'd1);
        checkOutput("fl.pre_count", 64'(count), 64'd3);
        checkOutput("fl.pre_z", 64'(z), 64'(mk(41)));
        applyStimulus(1'b1, mk(45), mk(55), 1'b0, 1'b0, 1'b1);
        checkOutput("fl.use_z", 64'(use_z), 64'd0);
        checkOutput("fl.count", 64'(count), 64'd0);
        checkOutput("fl.empty", 64'(empty), 64'd1);
        checkOutput("fl.full", 64'(full), 64'd0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("fl.req_use_z", 64'(use_z), 64'd0);
        idleCycle();
        checkOutput("fl.req2_use_z", 64'(use_z), 64'd0);
        checkOutput("fl.req_count", 64'(count), 64'd0);
        checkOutput("fl.z_retained", 64'(z), 64'(mk(41)));

        $display("[TB] wrap-around streaming");
        for (int i = 0; i < 4; i++) begin
            capturePair(100 + i, 200 + i);
        end
        checkOutput("wrap.full", 64'(full), 64'd1);
        for (int i = 0; i < 10; i++) begin
            doReplay($sformatf("wrap%0d", i), 100 + i, 200 + i, (i <= 6) ? 3 : 9 - i);
            if (i + 4 < 10) begin
                capturePair(104 + i, 204 + i);
            end
        end
        checkOutput("wrap.empty", 64'(empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
